// File: rtl/signed_unsigned_div.sv
// Sequential divider: 16-bit signed dividend by 8-bit unsigned divisor, truncating toward zero.
// One restoring shift-subtract step per cycle on magnitudes, sign fixed up in a final cycle.
module signed_unsigned_div (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_start,
  input  logic [15:0] i_a,
  input  logic [7:0]  i_b,
  output logic [15:0] o_q,
  output logic [8:0]  o_r,
  output logic        o_busy,
  output logic        o_done,
  output logic        o_dz
);

  typedef enum logic [1:0] {IDLE, CALC, SIGN, DONE} state_t;

  state_t      r_state;
  state_t      w_next;
  logic [15:0] r_quo;
  logic [7:0]  r_rem;
  logic [7:0]  r_div;
  logic        r_neg;
  logic [3:0]  r_cnt;
  logic [15:0] r_q;
  logic [8:0]  r_r;
  logic        r_dz;

  logic [15:0] w_mag;
  logic [8:0]  w_shift;
  logic        w_ge;
  logic [7:0]  w_sub;

  // |i_a| always fits 16 unsigned bits: -32768 negates to 16'h8000 = +32768.
  assign w_mag = i_a[15] ? (16'd0 - i_a) : i_a;

  // The remainder stays below the divisor, so 8 bits hold it between steps.
  assign w_shift = {r_rem, r_quo[15]};
  assign w_ge    = (w_shift >= {1'b0, r_div});
  assign w_sub   = w_shift[7:0] - r_div;

  // NOTE: every output of a combinational block gets a default first, so no path can infer a latch.
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (i_start) w_next = (i_b == 8'd0) ? DONE : CALC;
      CALC:    if (r_cnt == 4'd15) w_next = SIGN;
      SIGN:    w_next = DONE;
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= IDLE;
      r_quo   <= '0;
      r_rem   <= '0;
      r_div   <= '0;
      r_neg   <= 1'b0;
      r_cnt   <= '0;
      r_q     <= '0;
      r_r     <= '0;
      r_dz    <= 1'b0;
    end else begin
      r_state <= w_next;
      case (r_state)
        IDLE: begin
          if (i_start && i_b != 8'd0) begin
            r_quo <= w_mag;
            r_div <= i_b;
            r_neg <= i_a[15];
            r_rem <= '0;
            r_cnt <= '0;
          end else if (i_start) begin
            r_q  <= i_a[15] ? 16'h8000 : 16'h7fff;
            r_r  <= '0;
            r_dz <= 1'b1;
          end
        end
        CALC: begin
          r_rem <= w_ge ? w_sub : w_shift[7:0];
          r_quo <= {r_quo[14:0], w_ge};
          r_cnt <= r_cnt + 4'd1;
        end
        SIGN: begin
          r_q  <= r_neg ? (16'd0 - r_quo) : r_quo;
          r_r  <= r_neg ? (9'd0 - {1'b0, r_rem}) : {1'b0, r_rem};
          r_dz <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign o_q    = r_q;
  assign o_r    = r_r;
  assign o_dz   = r_dz;
  assign o_busy = (r_state == CALC) || (r_state == SIGN);
  assign o_done = (r_state == DONE);

endmodule

// File: tb/tb_signed_unsigned_div.sv
// Scoreboard bench for signed_unsigned_div: driver pushes expected results from an arithmetic
// model, a negedge monitor pops and compares on every o_done.
module tb_signed_unsigned_div;

  logic        clk;
  logic        i_rst;
  logic        i_start;
  logic [15:0] i_a;
  logic [7:0]  i_b;
  logic [15:0] o_q;
  logic [8:0]  o_r;
  logic        o_busy;
  logic        o_done;
  logic        o_dz;

  typedef struct {
    logic [15:0] q;
    logic [8:0]  r;
    logic        dz;
    int          done_cyc;
    int          busy_len;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   n_checks = 0;
  int   n_pass = 0;
  int   busy_cnt = 0;
  logic [25:0] last_out = '0;

  signed_unsigned_div dut (
    .i_clk  (clk),
    .i_rst  (i_rst),
    .i_start(i_start),
    .i_a    (i_a),
    .i_b    (i_b),
    .o_q    (o_q),
    .o_r    (o_r),
    .o_busy (o_busy),
    .o_done (o_done),
    .o_dz   (o_dz)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Reference: plain integer division truncates toward zero and % takes the dividend's sign.
  function automatic exp_t model(input int a, input int b, input int start_cyc);
    exp_t e;
    int q, r;
    if (b == 0) begin
      q = (a >= 0) ? 32767 : -32768;
      r = 0;
      e.dz = 1'b1;
      e.done_cyc = start_cyc + 1;
      e.busy_len = 0;
    end else begin
      q = a / b;
      r = a % b;
      e.dz = 1'b0;
      e.done_cyc = start_cyc + 1 + 17;
      e.busy_len = 17;
    end
    e.q = q[15:0];
    e.r = r[8:0];
    return e;
  endfunction

  // Monitor: compares on o_done, and checks outputs hold steady between completions.
  always @(negedge clk) begin
    if (i_rst) begin
      busy_cnt = 0;
      last_out = '0;
    end else if (o_done) begin
      if (sb.size() == 0) begin
        check("spurious_done", {31'd0, o_done}, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("quotient", {16'd0, o_q}, {16'd0, e.q});
        check("remainder", {23'd0, o_r}, {23'd0, e.r});
        check("dz_flag", {31'd0, o_dz}, {31'd0, e.dz});
        check("done_cycle", cyc, e.done_cyc);
        check("busy_len", busy_cnt, e.busy_len);
      end
      last_out = {o_q, o_r, o_dz};
      busy_cnt = 0;
    end else begin
      if (o_busy) busy_cnt++;
      else busy_cnt = 0;
      if ({o_q, o_r, o_dz} !== last_out)
        check("hold_outputs", {6'd0, o_q, o_r, o_dz}, {6'd0, last_out});
    end
  end

  task automatic wait_idle();
    bit ok = 0;
    for (int k = 0; k < 100 && !ok; k++) begin
      @(negedge clk);
      if (!o_busy && !o_done) ok = 1;
    end
    if (!ok) check("idle_timeout", {31'd0, o_busy}, 32'd0);
  endtask

  // Issues one start; afterwards scrambles the inputs to show they are no longer observed.
  task automatic do_op(input logic [15:0] a, input logic [7:0] b);
    wait_idle();
    i_start = 1'b1;
    i_a = a;
    i_b = b;
    sb.push_back(model(int'($signed(a)), int'(b), cyc));
    @(posedge clk);
    #1;
    i_start = 1'b0;
    i_a = 16'($urandom);
    i_b = 8'($urandom);
  endtask

  initial begin
    i_rst = 1'b1;
    i_start = 1'b1;
    i_a = 16'd5;
    i_b = 8'd0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", {31'd0, o_busy}, 32'd0);
    check("rst_done", {31'd0, o_done}, 32'd0);
    check("rst_outs", {6'd0, o_q, o_r, o_dz}, 32'd0);
    i_start = 1'b0;
    i_rst = 1'b0;

    do_op(16'd1000, 8'd7);
    do_op(-16'sd10, 8'd100);
    do_op(16'h8000, 8'd255);
    do_op(16'd32767, 8'd1);
    do_op(16'h8000, 8'd1);
    do_op(16'd5, 8'd0);
    do_op(-16'sd5, 8'd0);
    do_op(16'd0, 8'd0);
    do_op(16'd254, 8'd255);
    do_op(-16'sd255, 8'd255);

    // A start pulsed in CALC cycle 5 must be ignored; the next start lands right after o_done.
    do_op(16'd1000, 8'd7);
    repeat (4) @(posedge clk);
    #1;
    i_start = 1'b1;
    i_a = 16'd9;
    i_b = 8'd3;
    @(posedge clk);
    #1;
    i_start = 1'b0;
    do_op(16'd9, 8'd3);

    // Reset in CALC cycle 8 aborts the operation without a completion.
    do_op(16'd1000, 8'd7);
    repeat (7) @(posedge clk);
    #1;
    i_rst = 1'b1;
    @(posedge clk);
    #1;
    sb.delete();
    check("abort_busy", {31'd0, o_busy}, 32'd0);
    check("abort_done", {31'd0, o_done}, 32'd0);
    check("abort_outs", {6'd0, o_q, o_r, o_dz}, 32'd0);
    i_rst = 1'b0;
    repeat (25) @(posedge clk);
    do_op(16'd100, 8'd9);

    for (int n = 0; n < 40; n++) begin
      logic [7:0] b;
      case ($urandom_range(0, 5))
        0: b = 8'd0;
        1: b = 8'd1;
        2: b = 8'd255;
        default: b = 8'($urandom);
      endcase
      do_op(16'($urandom), b);
    end

    for (int k = 0; k < 100 && sb.size() != 0; k++) @(negedge clk);
    check("drain", sb.size(), 0);
    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
